// File: rtl/mult_share_arb.sv
// Round-robin arbiter feeding a two-stage pipeline around one shared 8x8 multiplier.
// Optional build macro MULT_SHARE_ARB_PRIO0_EN: requester 0 gets fixed priority over the rest.

module Multiplier_8x8 (
    input  logic [7:0]  In_1,
    input  logic [7:0]  In_2,
    input  logic        Sign,
    output logic [15:0] Out
);
    logic [15:0] ext_1;
    logic [15:0] ext_2;

    assign ext_1 = {{8{Sign & In_1[7]}}, In_1};
    assign ext_2 = {{8{Sign & In_2[7]}}, In_2};
    // Low 16 bits of the product of the extended operands is the exact result in both modes.
    assign Out = ext_1 * ext_2;
endmodule

module mult_share_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [N_REQ-1:0]     Req_Valid,
    output logic [N_REQ-1:0]     Req_Ready,
    input  logic [8*N_REQ-1:0]   Req_A,
    input  logic [8*N_REQ-1:0]   Req_B,
    input  logic [N_REQ-1:0]     Req_Sign,
    output logic                 Rsp_Valid,
    input  logic                 Rsp_Ready,
    output logic [ID_W-1:0]      Rsp_Id,
    output logic [15:0]          Rsp_Result
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a raised valid holds with stable payload until that edge, and ready may depend on valid.

    logic [ID_W-1:0] last;
    logic            s1_v;
    logic [7:0]      s1_a;
    logic [7:0]      s1_b;
    logic            s1_sign;
    logic [ID_W-1:0] s1_id;
    logic            s2_v;
    logic [15:0]     s2_result;
    logic [ID_W-1:0] s2_id;

    logic            s2_adv;
    logic            s1_adv;
    logic            acc_en;
    logic            grant_any;
    logic [ID_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant;
    logic            acc_fire;
    logic            last_upd;
    logic [15:0]     mult_out;

    // Returns {found, index}: first valid index after ptr, wrapping, optionally ignoring index 0.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [ID_W-1:0]  ptr,
                                              input logic             skip0);
        int cand;
        rr_pick = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = (int'(ptr) + off) % N_REQ;
            if (!rr_pick[ID_W] && valid[cand] && !(skip0 && cand == 0))
                rr_pick = {1'b1, ID_W'(cand)};
        end
    endfunction

    assign s2_adv = !s2_v | Rsp_Ready;
    assign s1_adv = !s1_v | s2_adv;
    assign acc_en = s1_adv;

    always_comb begin
        logic [ID_W:0] pick;
        grant_any = 1'b0;
        grant_idx = '0;
        last_upd  = 1'b0;
`ifdef MULT_SHARE_ARB_PRIO0_EN
        pick = rr_pick(Req_Valid, last, 1'b1);
        if (Req_Valid[0]) begin
            grant_any = 1'b1;
            grant_idx = '0;
        end else begin
            grant_any = pick[ID_W];
            grant_idx = pick[ID_W-1:0];
            last_upd  = pick[ID_W];
        end
`else
        pick = rr_pick(Req_Valid, last, 1'b0);
        grant_any = pick[ID_W];
        grant_idx = pick[ID_W-1:0];
        last_upd  = pick[ID_W];
`endif
    end

    always_comb begin
        grant = '0;
        if (grant_any)
            grant[grant_idx] = 1'b1;
    end

    assign Req_Ready = grant & {N_REQ{acc_en & Rst_n}};
    assign acc_fire  = grant_any & acc_en;

    Multiplier_8x8 u_mult (
        .In_1 (s1_a),
        .In_2 (s1_b),
        .Sign (s1_sign),
        .Out  (mult_out)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last      <= ID_W'(N_REQ - 1);
            s1_v      <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_sign   <= 1'b0;
            s1_id     <= '0;
            s2_v      <= 1'b0;
            s2_result <= '0;
            s2_id     <= '0;
        end else begin
            if (s1_adv) begin
                s1_v <= acc_fire;
                if (acc_fire) begin
                    s1_a    <= Req_A[8*int'(grant_idx) +: 8];
                    s1_b    <= Req_B[8*int'(grant_idx) +: 8];
                    s1_sign <= Req_Sign[grant_idx];
                    s1_id   <= grant_idx;
                end
            end
            if (acc_fire && last_upd)
                last <= grant_idx;
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_result <= mult_out;
                    s2_id     <= s1_id;
                end
            end
        end
    end

    assign Rsp_Valid  = s2_v;
    assign Rsp_Id     = s2_id;
    assign Rsp_Result = s2_result;
endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: directed arithmetic, fairness, backpressure, reset and random traffic.
module tb_mult_share_arb;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                 Clk = 1'b0;
    logic                 Rst_n;
    logic [N_REQ-1:0]     Req_Valid;
    logic [N_REQ-1:0]     Req_Ready;
    logic [8*N_REQ-1:0]   Req_A;
    logic [8*N_REQ-1:0]   Req_B;
    logic [N_REQ-1:0]     Req_Sign;
    logic                 Rsp_Valid;
    logic                 Rsp_Ready;
    logic [ID_W-1:0]      Rsp_Id;
    logic [15:0]          Rsp_Result;

    logic [7:0]           a_r [N_REQ];
    logic [7:0]           b_r [N_REQ];
    logic [N_REQ-1:0]     acc_mask;
    logic [ID_W+15:0]     exp_q [$];
    int                   acc_log [$];
    int                   checks = 0;
    int                   errors = 0;

    always #5 Clk = ~Clk;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            Req_A[8*i +: 8] = a_r[i];
            Req_B[8*i +: 8] = b_r[i];
        end
    end

    mult_share_arb #(.N_REQ(N_REQ)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Req_Valid  (Req_Valid),
        .Req_Ready  (Req_Ready),
        .Req_A      (Req_A),
        .Req_B      (Req_B),
        .Req_Sign   (Req_Sign),
        .Rsp_Valid  (Rsp_Valid),
        .Rsp_Ready  (Rsp_Ready),
        .Rsp_Id     (Rsp_Id),
        .Rsp_Result (Rsp_Result)
    );

    function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b,
                                              input logic s);
        int pa;
        int pb;
        int p;
        if (s) begin
            pa = int'($signed(a));
            pb = int'($signed(b));
        end else begin
            pa = int'(a);
            pb = int'(b);
        end
        p = pa * pb;
        return p[15:0];
    endfunction

    // Scoreboard: push on accept, pop and compare on response transfer.
    always @(negedge Clk) begin
        if (Rst_n) begin
            acc_mask = Req_Valid & Req_Ready;
            checks++;
            if ($countones(Req_Ready) > 1) begin
                errors++;
                $display("FAIL ready_onehot got=%b want at most one bit", Req_Ready);
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (acc_mask[i]) begin
                    exp_q.push_back({ID_W'(i), model_mul(a_r[i], b_r[i], Req_Sign[i])});
                    acc_log.push_back(i);
                end
            end
            if (Rsp_Valid && Rsp_Ready) begin
                logic [ID_W+15:0] e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected got id=%0d result=%h want no response",
                             Rsp_Id, Rsp_Result);
                end else begin
                    e = exp_q.pop_front();
                    if ({Rsp_Id, Rsp_Result} !== e) begin
                        errors++;
                        $display("FAIL rsp_data got id=%0d result=%h want id=%0d result=%h",
                                 Rsp_Id, Rsp_Result, e[ID_W+15:16], e[15:0]);
                    end
                end
            end
        end else begin
            acc_mask = '0;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (acc_mask[i]) begin
                a_r[i]      = 8'($urandom_range(0, 255));
                b_r[i]      = 8'($urandom_range(0, 255));
                Req_Sign[i] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic apply_reset();
        Rst_n     = 1'b0;
        Req_Valid = '0;
        repeat (2) @(posedge Clk);
        #1;
        exp_q.delete();
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        Rst_n     = 1'b0;
        Req_Valid = '1;
        Rsp_Ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            a_r[i] = 8'(i + 1);
            b_r[i] = 8'(i + 3);
        end
        Req_Sign = '0;
        repeat (2) @(posedge Clk);
        #2;
        checks++;
        if (Req_Ready !== '0 || Rsp_Valid !== 1'b0 || Rsp_Id !== '0 || Rsp_Result !== '0) begin
            errors++;
            $display("FAIL reset_state got ready=%b valid=%b id=%0d result=%h want 0 0 0 0",
                     Req_Ready, Rsp_Valid, Rsp_Id, Rsp_Result);
        end
        Req_Valid = '0;
        Rst_n     = 1'b1;
        step();
    endtask

    task automatic test_arith();
        int          ids  [4] = '{2, 2, 1, 3};
        logic [7:0]  ta   [4] = '{8'hFD, 8'hFD, 8'hFF, 8'hFF};
        logic [7:0]  tb   [4] = '{8'h05, 8'h05, 8'hFF, 8'hFF};
        logic        ts   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] tr   [4] = '{16'hFFF1, 16'h04F1, 16'hFE01, 16'h0001};
        Rsp_Ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_r[ids[k]]      = ta[k];
            b_r[ids[k]]      = tb[k];
            Req_Sign[ids[k]] = ts[k];
            Req_Valid        = N_REQ'(1 << ids[k]);
            @(negedge Clk);
            checks++;
            if (Req_Ready !== N_REQ'(1 << ids[k])) begin
                errors++;
                $display("FAIL arith_grant[%0d] got=%b want=%b", k, Req_Ready, N_REQ'(1 << ids[k]));
            end
            step();
            Req_Valid = '0;
            @(negedge Clk);
            checks++;
            if (Rsp_Valid !== 1'b0) begin
                errors++;
                $display("FAIL arith_early[%0d] got valid=%b want 0", k, Rsp_Valid);
            end
            @(negedge Clk);
            checks++;
            if (Rsp_Valid !== 1'b1 || Rsp_Id !== ID_W'(ids[k]) || Rsp_Result !== tr[k]) begin
                errors++;
                $display("FAIL arith_rsp[%0d] got v=%b id=%0d res=%h want v=1 id=%0d res=%h",
                         k, Rsp_Valid, Rsp_Id, Rsp_Result, ids[k], tr[k]);
            end
            step();
        end
    endtask

    task automatic check_order(input string name, input int want [$]);
        checks++;
        if (acc_log.size() != want.size()) begin
            errors++;
            $display("FAIL %s_count got=%0d want=%0d", name, acc_log.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                if (acc_log[i] != want[i]) begin
                    errors++;
                    $display("FAIL %s[%0d] got=%0d want=%0d", name, i, acc_log[i], want[i]);
                    break;
                end
            end
        end
    endtask

    task automatic drain(input string name);
        Req_Valid = '0;
        Rsp_Ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        step();
        checks++;
        if (exp_q.size() != 0 || Rsp_Valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain got pending=%0d valid=%b want 0 0", name, exp_q.size(), Rsp_Valid);
        end
    endtask

`ifdef MULT_SHARE_ARB_PRIO0_EN
    task automatic test_prio0();
        apply_reset();
        Rsp_Ready = 1'b1;
        Req_Valid = '1;
        acc_log.delete();
        repeat (6) step();
        check_order("prio0_all", '{0, 0, 0, 0, 0, 0});
        Req_Valid = 4'b1110;
        acc_log.delete();
        repeat (6) step();
        check_order("prio0_rest", '{1, 2, 3, 1, 2, 3});
        drain("prio0");
    endtask
`else
    task automatic test_fairness();
        apply_reset();
        Rsp_Ready = 1'b1;
        Req_Valid = '1;
        acc_log.delete();
        repeat (8) step();
        check_order("rr_all", '{0, 1, 2, 3, 0, 1, 2, 3});
        Req_Valid = 4'b1101;
        acc_log.delete();
        repeat (6) step();
        check_order("rr_drop1", '{0, 2, 3, 0, 2, 3});
        Req_Valid = 4'b1000;
        acc_log.delete();
        repeat (4) step();
        check_order("rr_single", '{3, 3, 3, 3});
        drain("fair");
    endtask
`endif

    task automatic test_backpressure();
        logic [ID_W-1:0] hold_id;
        logic [15:0]     hold_res;
        drain("bp_pre");
        Rsp_Ready = 1'b0;
        Req_Valid = '1;
        acc_log.delete();
        hold_id  = '0;
        hold_res = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            if (c == 2) begin
                hold_id  = Rsp_Id;
                hold_res = Rsp_Result;
            end
            if (c >= 2) begin
                checks++;
                if (Req_Ready !== '0 || Rsp_Valid !== 1'b1 || Rsp_Id !== hold_id ||
                    Rsp_Result !== hold_res) begin
                    errors++;
                    $display("FAIL bp_hold[%0d] got ready=%b v=%b id=%0d res=%h want 0 1 %0d %h",
                             c, Req_Ready, Rsp_Valid, Rsp_Id, Rsp_Result, hold_id, hold_res);
                end
            end
            step();
        end
        checks++;
        if (acc_log.size() != 2) begin
            errors++;
            $display("FAIL bp_accepts got=%0d want=2", acc_log.size());
        end
        drain("bp");
    endtask

    task automatic test_reset_mid();
        Rsp_Ready = 1'b0;
        Req_Valid = '1;
        repeat (3) step();
        checks++;
        if (Rsp_Valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre got valid=%b want 1", Rsp_Valid);
        end
        Rst_n = 1'b0;
        #1;
        checks++;
        if (Rsp_Valid !== 1'b0 || Req_Ready !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear got valid=%b ready=%b want 0 0", Rsp_Valid, Req_Ready);
        end
        exp_q.delete();
        @(posedge Clk);
        #1;
        Rst_n     = 1'b1;
        Rsp_Ready = 1'b1;
        acc_log.delete();
        @(negedge Clk);
        checks++;
        if (Rsp_Valid !== 1'b0 || Req_Ready !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_after got valid=%b ready=%b want 0 0001", Rsp_Valid, Req_Ready);
        end
        step();
        check_order("rst_mid_first", '{0});
        drain("rst_mid");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            Rsp_Ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N_REQ; i++)
                if (!Req_Valid[i] || acc_mask[i])
                    Req_Valid[i] = 1'($urandom_range(0, 1));
            step();
        end
        drain("random");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_arith();
`ifdef MULT_SHARE_ARB_PRIO0_EN
        test_prio0();
`else
        test_fairness();
`endif
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
